// File: rtl/instruction_memory_pkg.sv
// Shared CPU package: widths and defaults used by the fetch path and its memories.
package instruction_memory_pkg;

  // One instruction is three bytes, fetched big-endian.
  localparam int INSTR_W         = 24;
  localparam int BYTE_W          = 8;
  localparam int PC_W            = 24;
  localparam int BYTES_PER_INSTR = INSTR_W / BYTE_W;

  // Default program memory size in bytes.
  localparam int DEFAULT_DEPTH   = 256;

endpackage : instruction_memory_pkg

// File: rtl/instruction_memory.sv
// Byte-addressed program memory with a zero-latency, three-byte instruction
// fetch port and a one-byte-per-cycle load port.
//
// Fetch bytes whose address lies at or beyond DEPTH read as zero. Addresses
// are extended to PC_W+1 bits before the +1/+2 offsets, so a PC near the top
// of the 24-bit space never wraps around into low memory.
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    PC,
  output logic [INSTR_W-1:0] Instruction,
  input  logic               load_en,
  input  logic [AW-1:0]      load_addr,
  input  logic [BYTE_W-1:0]  load_data
);

  localparam int            FETCH_AW  = PC_W + 1;
  localparam logic [FETCH_AW-1:0] DEPTH_EXT = FETCH_AW'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];

  // Returns the byte at a fetch address, or zero when it falls outside the array.
  function automatic logic [BYTE_W-1:0] fetch_byte(input logic [FETCH_AW-1:0] addr);
    if (addr < DEPTH_EXT) begin
      return mem_q[addr[AW-1:0]];
    end
    return '0;
  endfunction

  // Program load port; an asserted reset wipes the whole program.
  // NOTE: the array is reset element by element because every byte must read
  // as zero the instant rst_n falls; this forces flops rather than a RAM macro.
  // NOTE: state is updated with non-blocking assignments so fetch logic and
  // any other clocked reader see the pre-edge value during the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Combinational fetch: mem[PC] lands in the top byte, mem[PC+2] in the bottom.
  // NOTE: Instruction gets a default before the loop so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    logic [FETCH_AW-1:0] base;
    base        = {1'b0, PC};
    Instruction = '0;
    for (int i = 0; i < BYTES_PER_INSTR; i++) begin
      Instruction[INSTR_W-1-i*BYTE_W -: BYTE_W] = fetch_byte(base + FETCH_AW'(i));
    end
  end

endmodule : instruction_memory

// File: tb/tb_instruction_memory.sv
// Directed, scoreboard-checked bench for instruction_memory.
module tb_instruction_memory;

  logic        clk;
  logic        rst_n;
  logic [23:0] PC;
  logic [23:0] Instruction;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [7:0]  load_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [23:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  instruction_memory #(.DEPTH(256), .AW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PC         (PC),
    .Instruction(Instruction),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push an expected fetch result for the PC about to be observed.
  task automatic expect_instr(input string tag, input logic [23:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare against the live output.
  task automatic check();
    sb_entry_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%h", Instruction);
      return;
    end
    e = sb_q.pop_front();
    assert (Instruction === e.exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", e.tag, Instruction, e.exp);
    end
  endtask

  // Set PC, record the expectation, let the combinational path settle, compare.
  task automatic fetch(input string tag, input logic [23:0] pc, input logic [23:0] exp);
    PC = pc;
    expect_instr(tag, exp);
    #1;
    check();
  endtask

  // One load-port write, returning 1 time unit after the write edge.
  task automatic load_byte(input logic [7:0] addr, input logic [7:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    @(posedge clk);
    #1;
    load_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    PC        = 24'd0;
    load_en   = 1'b0;
    load_addr = 8'd0;
    load_data = 8'd0;

    // Reset state.
    #2;
    fetch("reset_pc13", 24'd13, 24'h000000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load and big-endian fetch, including an unaligned PC.
    load_byte(8'd13, 8'hA1);
    load_byte(8'd14, 8'hB2);
    load_byte(8'd15, 8'hC3);
    fetch("load_pc13", 24'd13, 24'hA1B2C3);
    fetch("load_pc14", 24'd14, 24'hB2C300);
    fetch("load_pc15", 24'd15, 24'hC30000);
    fetch("load_pc12", 24'd12, 24'h00A1B2);

    // Top-of-array boundary and no wrap-around.
    load_byte(8'd255, 8'h7E);
    fetch("bound_pc255",    24'd255,     24'h7E0000);
    fetch("bound_pc254",    24'd254,     24'h007E00);
    fetch("bound_pc253",    24'd253,     24'h00007E);
    fetch("bound_pc256",    24'h000100,  24'h000000);
    fetch("bound_pcffffff", 24'hFFFFFF,  24'h000000);
    fetch("bound_pcfffffe", 24'hFFFFFE,  24'h000000);

    // Same-cycle write and fetch: old byte before the edge, new byte after.
    PC        = 24'd20;
    load_en   = 1'b1;
    load_addr = 8'd20;
    load_data = 8'h55;
    expect_instr("same_cycle_before", 24'h000000);
    #1;
    check();
    @(posedge clk);
    expect_instr("same_cycle_after", 24'h550000);
    #1;
    check();
    load_en = 1'b0;

    // Write-disable: three cycles with load_en low change nothing.
    load_addr = 8'd5;
    load_data = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    fetch("wdis_pc5",  24'd5,  24'h000000);
    fetch("wdis_pc13", 24'd13, 24'hA1B2C3);

    // Writes ignored while reset is held; a write on the first edge after release lands.
    rst_n = 1'b0;
    #1;
    load_en   = 1'b1;
    load_addr = 8'd30;
    load_data = 8'h99;
    @(posedge clk); #1;
    fetch("rst_write_ignored", 24'd30, 24'h000000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
    fetch("rst_release_write", 24'd30, 24'h990000);

    // Mid-load reset clears everything without a clock edge.
    load_byte(8'd0, 8'h11);
    load_byte(8'd1, 8'h22);
    load_byte(8'd2, 8'h33);
    fetch("midload_loaded", 24'd0, 24'h112233);
    rst_n = 1'b0;
    fetch("midload_pc0",   24'd0,   24'h000000);
    fetch("midload_pc13",  24'd13,  24'h000000);
    fetch("midload_pc254", 24'd254, 24'h000000);
    fetch("midload_pc30",  24'd30,  24'h000000);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fetch("post_reset_pc1", 24'd1, 24'h000000);

    checks++;
    assert (sb_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instruction_memory

// File: doc/instruction_memory.md
INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter DEPTH, default 256, number of byte locations in the memory array.
REQ-002 Parameter AW, default 8, byte-address width used to index the array (2**AW = DEPTH).
REQ-003 clk  input  1  single system clock; all writes occur on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 PC  input  24  byte address of the instruction to fetch.
REQ-006 Instruction  output  24  fetched instruction word.
REQ-007 load_en  input  1  byte-write enable for program loading.
REQ-008 load_addr  input  AW  byte address to write.
REQ-009 load_data  input  8  byte value to write.

Function
REQ-010 Storage SHALL be DEPTH bytes, byte-addressed, 8 bits per location.
REQ-011 Instruction SHALL be combinational from PC, with zero clock latency: {mem[PC], mem[PC+1], mem[PC+2]}, big-endian, so mem[PC] drives bits 23:16.
REQ-012 Any byte address (PC, PC+1 or PC+2) >= DEPTH SHALL read as 8'h00; there is no wrap-around.
REQ-013 PC+1 and PC+2 SHALL be computed at 25-bit width, so PC near 24'hFFFFFF does not overflow into low addresses.
REQ-014 On a rising clk edge with load_en=1 and rst_n=1, mem[load_addr] SHALL take load_data.
REQ-015 Instruction SHALL reflect a written byte immediately after the write edge; before that edge it SHALL show the old value (read-before-write within the cycle).
REQ-016 load_en=0 SHALL leave memory unchanged; PC SHALL never cause a write.
REQ-017 PC is not required to be aligned; any byte address is a legal fetch.

Reset
REQ-018 rst_n=0 SHALL asynchronously clear every memory byte to 8'h00, independent of clk, so Instruction reads 24'h000000 for every PC.
REQ-019 While rst_n=0, writes SHALL be ignored.
REQ-020 Deassertion of rst_n SHALL take effect at the next clk edge; a write requested on that edge is accepted.
REQ-021 Reset asserted in the middle of a load sequence SHALL discard all previously loaded bytes.

Structure
REQ-022 The shared CPU package SHALL hold the instruction width (24), the byte width (8) and the default DEPTH.
REQ-023 The module SHALL be a single module with no sub-modules; the byte-fetch helper that implements the REQ-012 rule is an internal function.

Verification
REQ-024 Reset test: assert rst_n=0, set PC=13 -> Instruction=24'h000000.
REQ-025 Load test: write bytes 8'hA1, 8'hB2, 8'hC3 to addresses 13, 14, 15, then set PC=13 -> Instruction=24'hA1B2C3; PC=14 -> 24'hB2C300.
REQ-026 Boundary test: write 8'h7E at address 255, then set PC=255 -> Instruction=24'h7E0000; PC=254 -> 24'h007E00; PC=24'h000100 -> 24'h000000.
REQ-027 Same-cycle test: PC=20 with load_en=1, load_addr=20, load_data=8'h55 -> Instruction bits 23:16 show the old byte before the edge and 8'h55 after it.
REQ-028 Mid-load reset test: load addresses 0-2, pulse rst_n low between clock edges -> PC=0 gives 24'h000000 immediately, without waiting for a clock edge.
REQ-029 Write-disable test: present load_addr=5, load_data=8'hFF with load_en=0 for 3 clock cycles -> PC=5 still gives 24'h000000.
